// File: rtl/add_hdr.sv
// add_hdr: store-and-forward packet buffer that prepends one module-header word
// (word count, source port, byte count). Define ADD_HDR_RUNT_DROP_EN to discard packets under 60 bytes.
//
// state  | meaning
// IDLE   | waiting for a complete packet in the length FIFO
// HDR    | presenting the header word, advances on out_rdy
// DATA   | streaming stored packet words, one per out_rdy cycle
// DROP   | draining a runt packet's words without asserting out_wr
module add_hdr #(
   parameter int DATA_WIDTH  = 64,
   parameter int CTRL_WIDTH  = DATA_WIDTH/8,
   parameter int STAGE_NUM   = 8'hFF,
   parameter int PORT_NUMBER = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy
);

   localparam int DF_DEPTH = 512;
   localparam int DF_AW    = 9;
   localparam int LF_DEPTH = 16;
   localparam int LF_AW    = 4;
   localparam int DF_W     = DATA_WIDTH + CTRL_WIDTH;
   localparam int LF_W     = 33;

   localparam logic [DF_AW:0] DF_FULL  = (DF_AW+1)'(DF_DEPTH);
   localparam logic [DF_AW:0] DF_HIWAT = (DF_AW+1)'(DF_DEPTH - 8);
   localparam logic [LF_AW:0] LF_FULL  = (LF_AW+1)'(LF_DEPTH);
   localparam logic [LF_AW:0] LF_HIWAT = (LF_AW+1)'(LF_DEPTH - 2);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

   // Bytes valid in the final word: CTRL_WIDTH minus index of the highest set marker bit.
   function automatic logic [15:0] last_bytes(input logic [CTRL_WIDTH-1:0] ctrl);
      int msb;
      msb = 0;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
         if (ctrl[i]) msb = i;
      end
      return 16'(CTRL_WIDTH - msb);
   endfunction

   logic [DF_W-1:0]  df_mem [DF_DEPTH];
   logic [LF_W-1:0]  lf_mem [LF_DEPTH];
   logic [DF_AW-1:0] df_wr_ptr, df_rd_ptr;
   logic [DF_AW:0]   df_cnt;
   logic [LF_AW-1:0] lf_wr_ptr, lf_rd_ptr;
   logic [LF_AW:0]   lf_cnt;

   logic        in_last, df_wr, lf_wr, df_rd, lf_rd, pkt_drop;
   logic [15:0] wcnt, pkt_w, pkt_b;

   state_t      state, state_nxt;
   logic [15:0] rem, hdr_w, hdr_b;
   logic [DF_W-1:0] df_head;
   logic [LF_W-1:0] lf_head;
   logic [15:0] head_w, head_b;
   logic        head_drop;
   logic [63:0] hdr64;

   // ---------------- input side ----------------
   assign in_last = |in_ctrl;
   // A word is taken whenever room exists, regardless of in_rdy, so a late writer never overflows.
   assign df_wr   = in_wr && (df_cnt != DF_FULL) && (!in_last || (lf_cnt != LF_FULL));
   assign lf_wr   = df_wr && in_last;
   assign in_rdy  = (df_cnt < DF_HIWAT) && (lf_cnt < LF_HIWAT);

   assign pkt_w   = wcnt + 16'd1;
   assign pkt_b   = {wcnt[12:0], 3'b000} + last_bytes(in_ctrl);

`ifdef ADD_HDR_RUNT_DROP_EN
   assign pkt_drop = (pkt_b < 16'd60);
`else
   assign pkt_drop = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (df_wr) df_mem[df_wr_ptr] <= {in_ctrl, in_data};
      if (lf_wr) lf_mem[lf_wr_ptr] <= {pkt_w, pkt_b, pkt_drop};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         df_wr_ptr <= '0;
         df_rd_ptr <= '0;
         df_cnt    <= '0;
         lf_wr_ptr <= '0;
         lf_rd_ptr <= '0;
         lf_cnt    <= '0;
         wcnt      <= '0;
      end else begin
         if (df_wr) df_wr_ptr <= df_wr_ptr + 1'b1;
         if (df_rd) df_rd_ptr <= df_rd_ptr + 1'b1;
         case ({df_wr, df_rd})
            2'b10:   df_cnt <= df_cnt + 1'b1;
            2'b01:   df_cnt <= df_cnt - 1'b1;
            default: df_cnt <= df_cnt;
         endcase
         if (lf_wr) lf_wr_ptr <= lf_wr_ptr + 1'b1;
         if (lf_rd) lf_rd_ptr <= lf_rd_ptr + 1'b1;
         case ({lf_wr, lf_rd})
            2'b10:   lf_cnt <= lf_cnt + 1'b1;
            2'b01:   lf_cnt <= lf_cnt - 1'b1;
            default: lf_cnt <= lf_cnt;
         endcase
         if (df_wr) wcnt <= in_last ? 16'd0 : wcnt + 16'd1;
      end
   end

   // ---------------- output side ----------------
   assign df_head   = df_mem[df_rd_ptr];
   assign lf_head   = lf_mem[lf_rd_ptr];
   assign head_w    = lf_head[32:17];
   assign head_b    = lf_head[16:1];
   assign head_drop = lf_head[0];
   assign hdr64     = {16'h0000, hdr_w, 16'(PORT_NUMBER), hdr_b};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         rem   <= '0;
         hdr_w <= '0;
         hdr_b <= '0;
      end else begin
         state <= state_nxt;
         if (lf_rd) begin
            rem   <= head_w;
            hdr_w <= head_w;
            hdr_b <= head_b;
         end else if (df_rd) begin
            rem   <= rem - 16'd1;
         end
      end
   end

   // out_wr is qualified by out_rdy combinationally so a stalled cycle never carries a word.
   always_comb begin
      state_nxt = state;
      out_wr    = 1'b0;
      out_data  = '0;
      out_ctrl  = '0;
      df_rd     = 1'b0;
      lf_rd     = 1'b0;
      case (state)
         S_IDLE: begin
            if (lf_cnt != '0) begin
               lf_rd     = 1'b1;
               state_nxt = head_drop ? S_DROP : S_HDR;
            end
         end
         S_HDR: begin
            out_data = DATA_WIDTH'(hdr64);
            out_ctrl = CTRL_WIDTH'(STAGE_NUM);
            if (out_rdy) begin
               out_wr    = 1'b1;
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            out_data = df_head[DATA_WIDTH-1:0];
            out_ctrl = df_head[DF_W-1:DATA_WIDTH];
            if (out_rdy) begin
               out_wr = 1'b1;
               df_rd  = 1'b1;
               if (rem == 16'd1) state_nxt = S_IDLE;
            end
         end
         S_DROP: begin
            df_rd = 1'b1;
            if (rem == 16'd1) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_add_hdr.sv
// tb_add_hdr: random and directed packets against a queue-based reference of the
// header-insertion rules; an independent monitor pops and compares every output word.
module tb_add_hdr;

   localparam int DW   = 64;
   localparam int CW   = 8;
   localparam int PORT = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          in_wr = 1'b0;
   logic          in_rdy;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          out_wr;
   logic          out_rdy = 1'b0;

   add_hdr #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STAGE_NUM(8'hFF), .PORT_NUMBER(PORT)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
      .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   int exp_words = 0, got_words = 0, acc_words = 0;
   int hdr_cyc = 0, last_wr_cyc = 0, cur_run = 0, last_run = 0;
   int rdy_mode = 0;
   logic [71:0] exp_q[$];

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference: header fields follow directly from packet length and final-word marker.
   task automatic push_pkt(input logic [63:0] words[$], input logic [7:0] last_ctrl);
      int w, b;
      w = words.size();
      b = 8 * (w - 1) + (8 - $clog2(last_ctrl));
`ifdef ADD_HDR_RUNT_DROP_EN
      if (b < 60) return;
`endif
      exp_q.push_back({8'hFF, 16'h0000, 16'(w), 16'(PORT), 16'(b)});
      for (int i = 0; i < w; i++)
         exp_q.push_back({(i == w - 1) ? last_ctrl : 8'h00, words[i]});
      exp_words += w + 1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       out_rdy = 1'b1;
         1:       out_rdy = ~out_rdy;
         2:       out_rdy = 1'b0;
         default: out_rdy = 1'($urandom_range(0, 1));
      endcase
   end

   initial forever begin
      logic [71:0] e;
      @(negedge clk);
      if (reset && out_wr) begin
         check("out_wr_gated", 72'(out_rdy), 72'(1));
         got_words++;
         cur_run++;
         if (out_ctrl == 8'hFF) hdr_cyc = cyc;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h want none", {out_ctrl, out_data});
         end else begin
            e = exp_q.pop_front();
            check("out_word", {out_ctrl, out_data}, e);
         end
      end else if (cur_run != 0) begin
         last_run = cur_run;
         cur_run  = 0;
      end
   end

   // Entered and left at posedge+1.
   task automatic send_pkt(input int len, input logic [7:0] last_ctrl, input int max_gap);
      logic [63:0] words[$];
      logic [63:0] w;
      int guard;
      for (int i = 0; i < len; i++) begin
         w = {$urandom, $urandom};
         words.push_back(w);
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
         end
         guard = 0;
         while (!in_rdy && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
         end
         if (!in_rdy) begin
            total++;
            bad++;
            $display("FAIL in_rdy_timeout: got in_rdy=0 want 1 within 5000 cycles");
            return;
         end
         in_data = w;
         in_ctrl = (i == len - 1) ? last_ctrl : 8'h00;
         in_wr   = 1'b1;
         acc_words++;
         if (i == len - 1) begin
            last_wr_cyc = cyc;
            push_pkt(words, last_ctrl);
         end
         @(posedge clk);
         #1;
         in_wr   = 1'b0;
         in_ctrl = 8'h00;
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 40000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      check("drain_empty", 72'(exp_q.size()), 72'(0));
      check("word_count", 72'(got_words), 72'(exp_words));
   endtask

   initial begin
      int d, g0, a0, guard;
      #2;
      check("rst_out_wr", 72'(out_wr), 72'(0));
      check("rst_out_data", 72'(out_data), 72'(0));
      check("rst_out_ctrl", 72'(out_ctrl), 72'(0));
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_rdy", 72'(in_rdy), 72'(1));

      // 8-word packet, last ctrl 04: W=8 B=62, latency and back-to-back run
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      send_pkt(8, 8'h04, 0);
      wait_drain();
      d = hdr_cyc - last_wr_cyc;
      total++;
      if (d < 2 || d > 4) begin
         bad++;
         $display("FAIL hdr_latency: got %0d cycles want 2..4", d);
      end
      check("run_length", 72'(last_run), 72'(9));

      // single-word packet, ctrl 80
      send_pkt(1, 8'h80, 0);
      wait_drain();

      // random lengths, markers, gaps and back-pressure
      rdy_mode = 3;
      for (int p = 0; p < 25; p++)
         send_pkt($urandom_range(1, 24), 8'(1 << $urandom_range(0, 7)), 2);
      wait_drain();

      // three 64-word packets with out_rdy toggling
      rdy_mode = 1;
      g0 = got_words;
      for (int p = 0; p < 3; p++) send_pkt(64, 8'h01, 0);
      wait_drain();
      check("toggle_words", 72'(got_words - g0), 72'(195));

      // output blocked while 70 full-size packets arrive
      rdy_mode = 2;
      @(posedge clk);
      #1;
      a0 = acc_words;
      fork
         begin
            for (int p = 0; p < 70; p++) send_pkt(190, 8'h08, 0);
         end
         begin
            guard = 0;
            while (in_rdy && guard < 2000) begin
               @(posedge clk);
               #1;
               guard++;
            end
            check("in_rdy_fall", 72'(in_rdy), 72'(0));
            check("fill_level", 72'(acc_words - a0), 72'(504));
            repeat (10) begin
               @(posedge clk);
               #1;
            end
            check("stall_hold", 72'(acc_words - a0), 72'(504));
            rdy_mode = 0;
         end
      join
      wait_drain();

      // reset with output mid-packet and a partial input packet
      rdy_mode = 0;
      send_pkt(30, 8'h01, 0);
      for (int i = 0; i < 3; i++) begin
         in_data = {$urandom, $urandom};
         in_ctrl = 8'h00;
         in_wr   = 1'b1;
         @(posedge clk);
         #1;
         in_wr = 1'b0;
      end
      check("pre_reset_out_wr", 72'(out_wr), 72'(1));
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_out_wr", 72'(out_wr), 72'(0));
      check("mid_rst_out_data", 72'(out_data), 72'(0));
      check("mid_rst_out_ctrl", 72'(out_ctrl), 72'(0));
      exp_q.delete();
      exp_words = got_words;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      check("post_rst_in_rdy", 72'(in_rdy), 72'(1));
      @(posedge clk);
      #1;
      send_pkt(9, 8'h01, 0);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
